// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared image geometry defaults, grey coefficients and FSM state type
// Contents:
//   DEF_IMG_WIDTH / DEF_IMG_HEIGHT : default frame geometry
//   COEF_R / COEF_G / COEF_B       : luma weights, sum to 256 so >>8 normalises
//   SUM_W                          : width of the unsigned weighted-sum intermediate
//   state_t                        : IDLE / STREAM / FLUSH
//   weigh()                        : one coefficient * channel product at SUM_W bits
package img_pkg;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  localparam int SUM_W = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  function automatic logic [SUM_W-1:0] weigh(input logic [7:0] coef, input logic [7:0] chan);
    return SUM_W'(coef) * SUM_W'(chan);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - show-ahead synchronous FIFO for tagged grey pixels
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   push, push_data   : write request and entry (ignored when full)
//   pop, pop_data     : read request (ignored when empty), head entry shown ahead
//   full, empty, count: occupancy status, count runs 0..DEPTH
module pixel_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: nothing reads it while count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rgb_gray_streamer.sv
// rtl/rgb_gray_streamer.sv - RGB888 to grey converter with frame tagging and output buffer
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   rgb_in, rgb_in_valid           : input pixel {R,G,B} and its valid
//   rgb_in_ready                   : pixel accepted when high together with valid
//   pixel_out, pixel_out_valid     : grey pixel from FIFO head, valid = FIFO not empty
//   pixel_out_ready                : consumer takes pixel_out this cycle
//   sof_out, eol_out               : start-of-frame / end-of-line tags of the head pixel
//   frame_done                     : one-cycle pulse once the last frame pixel has left
//   busy                           : state is not IDLE
module rgb_gray_streamer
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [23:0]           rgb_in,
  input  logic                  rgb_in_valid,
  output logic                  rgb_in_ready,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_out_valid,
  input  logic                  pixel_out_ready,
  output logic                  sof_out,
  output logic                  eol_out,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int FW = DATA_WIDTH + 2;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              run;
  logic              accept;
  logic              at_sof;
  logic              at_eol;
  logic              at_last;
  logic              pipe_empty;
  logic              frame_end;

  logic              v1;
  logic [SUM_W-1:0]  prod_r;
  logic [SUM_W-1:0]  prod_g;
  logic [SUM_W-1:0]  prod_b;
  logic              sof1;
  logic              eol1;
  logic [SUM_W-1:0]  sum;
  logic [DATA_WIDTH-1:0] grey;

  logic [FW-1:0]     fifo_in;
  logic [FW-1:0]     fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     occupancy;

  assign at_sof  = (x == '0) && (y == '0);
  assign at_eol  = (x == X_LAST);
  assign at_last = at_eol && (y == Y_LAST);

  // Credit scheme: a pixel in the multiply stage already owns a FIFO slot,
  // so the FIFO can never be pushed while full.
  assign occupancy    = fifo_count + CW'(v1);
  assign rgb_in_ready = run && (occupancy < CW'(FIFO_DEPTH)) &&
                        ((state == IDLE) || (state == STREAM));
  assign accept       = rgb_in_valid && rgb_in_ready;
  assign pipe_empty   = !v1 && fifo_empty;

  // run holds ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run <= 1'b0;
    else        run <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      IDLE, STREAM: begin
        if (accept) state_nxt = at_last ? FLUSH : STREAM;
      end
      FLUSH: begin
        if (pipe_empty) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign frame_done = frame_end;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (frame_end) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (at_eol) begin
        x <= '0;
        y <= at_last ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Multiply stage: products and tags registered on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1     <= 1'b0;
      prod_r <= '0;
      prod_g <= '0;
      prod_b <= '0;
      sof1   <= 1'b0;
      eol1   <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        prod_r <= weigh(COEF_R, rgb_in[23:16]);
        prod_g <= weigh(COEF_G, rgb_in[15:8]);
        prod_b <= weigh(COEF_B, rgb_in[7:0]);
        sof1   <= at_sof;
        eol1   <= at_eol;
      end
    end
  end

  // Sum/shift stage feeds the FIFO write port directly; truncation, no rounding.
  assign sum     = prod_r + prod_g + prod_b;
  assign grey    = DATA_WIDTH'(sum >> 8);
  assign fifo_in = {sof1, eol1, grey};

  pixel_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (v1 && !fifo_full),
    .push_data (fifo_in),
    .pop       (pixel_out_ready),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Head fields are masked while empty so unwritten storage never shows.
  assign pixel_out_valid = !fifo_empty;
  assign pixel_out       = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
  assign sof_out         = !fifo_empty && fifo_head[FW-1];
  assign eol_out         = !fifo_empty && fifo_head[FW-2];

endmodule

// File: tb/tb_rgb_gray_streamer.sv
// tb/tb_rgb_gray_streamer.sv - directed and randomised-handshake bench for rgb_gray_streamer
module tb_rgb_gray_streamer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NP = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] rgb_in = '0;
  logic        rgb_in_valid = 1'b0;
  logic        rgb_in_ready;
  logic [7:0]  pixel_out;
  logic        pixel_out_valid;
  logic        pixel_out_ready = 1'b1;
  logic        sof_out;
  logic        eol_out;
  logic        frame_done;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [9:0] out_q[$];
  logic       in_done;

  logic [23:0] vec1 [NP] = '{24'hFF0000, 24'hFFFFFF, 24'h000000, 24'h00FF00,
                             24'h0000FF, 24'h808080, 24'h102030, 24'h123456};
  logic [7:0]  g1   [NP] = '{8'd76, 8'd255, 8'd0, 8'd149, 8'd28, 8'd128, 8'd29, 8'd45};

  rgb_gray_streamer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rgb_in          (rgb_in),
    .rgb_in_valid    (rgb_in_valid),
    .rgb_in_ready    (rgb_in_ready),
    .pixel_out       (pixel_out),
    .pixel_out_valid (pixel_out_valid),
    .pixel_out_ready (pixel_out_ready),
    .sof_out         (sof_out),
    .eol_out         (eol_out),
    .frame_done      (frame_done),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Output transfers and frame_done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (pixel_out_valid && pixel_out_ready) out_q.push_back({sof_out, eol_out, pixel_out});
    if (frame_done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] gray_ref(input logic [23:0] v);
    int s;
    s = 77 * int'(v[23:16]) + 150 * int'(v[15:8]) + 29 * int'(v[7:0]);
    return 8'(s >> 8);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [23:0] v);
    int t;
    rgb_in = v;
    rgb_in_valid = 1'b1;
    t = 0;
    while (!rgb_in_ready && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: rgb_in_ready stayed %0b, required 1", rgb_in_ready);
    end
    tick();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || pixel_out_valid) && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: busy=%0b valid=%0b, required 0/0", busy, pixel_out_valid);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    tick();
    n_cmp++; if (rgb_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %0b want 0", rgb_in_ready); end
    n_cmp++; if (pixel_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", pixel_out_valid); end
    n_cmp++; if (pixel_out !== 8'd0) begin n_err++; $display("FAIL rst_pixel: got %0d want 0", pixel_out); end
    n_cmp++; if ({sof_out, eol_out, frame_done, busy} !== 4'b0) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {sof_out, eol_out, frame_done, busy}); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (rgb_in_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge: got %0b want 0", rgb_in_ready); end
    tick();
    n_cmp++; if (rgb_in_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_edge: got %0b want 1", rgb_in_ready); end
  endtask

  task automatic test_red_latency();
    int lat;
    out_q.delete();
    done_cnt = 0;
    pixel_out_ready = 1'b1;
    rgb_in = 24'hFF0000;
    rgb_in_valid = 1'b1;
    n_cmp++; if (rgb_in_ready !== 1'b1) begin n_err++; $display("FAIL red_ready: got %0b want 1", rgb_in_ready); end
    tick();
    rgb_in_valid = 1'b0;
    lat = 1;
    while (!pixel_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    n_cmp++; if (lat != 2) begin n_err++; $display("FAIL red_latency: got %0d want 2", lat); end
    n_cmp++; if (pixel_out !== 8'd76) begin n_err++; $display("FAIL red_pixel: got %0d want 76", pixel_out); end
    n_cmp++; if ({sof_out, eol_out} !== 2'b10) begin n_err++; $display("FAIL red_tags: got %b want 10", {sof_out, eol_out}); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL red_busy: got %0b want 1", busy); end
  endtask

  // Continues the frame started by test_red_latency.
  task automatic test_frame();
    logic [9:0] e;
    for (int i = 1; i < NP; i++) send_pixel(vec1[i]);
    rgb_in_valid = 1'b0;
    wait_idle();
    n_cmp++; if (out_q.size() != NP) begin n_err++; $display("FAIL frame_count: got %0d want %0d", out_q.size(), NP); end
    for (int i = 0; i < NP && i < out_q.size(); i++) begin
      e = {(i == 0), (i % W == W - 1), g1[i]};
      n_cmp++; if (out_q[i] !== e) begin n_err++; $display("FAIL frame_px%0d: got %h want %h", i, out_q[i], e); end
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL frame_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL frame_busy: got %0b want 0", busy); end
  endtask

  task automatic test_stall();
    logic [23:0] v2 [NP];
    logic [9:0]  e;
    logic        acc;
    int          idx;
    for (int i = 0; i < NP; i++) v2[i] = {8'(i * 30 + 5), 8'(250 - i * 20), 8'(i * 7 + 3)};
    out_q.delete();
    done_cnt = 0;
    pixel_out_ready = 1'b0;
    idx = 0;
    rgb_in = v2[0];
    rgb_in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      acc = rgb_in_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < NP) rgb_in = v2[idx];
      end
      if (pixel_out_valid) begin
        n_cmp++;
        if ({sof_out, pixel_out} !== {1'b1, gray_ref(v2[0])}) begin
          n_err++; $display("FAIL stall_hold c%0d: got %b/%0d want 1/%0d", c, sof_out, pixel_out, gray_ref(v2[0]));
        end
      end
    end
    n_cmp++; if (idx != 4) begin n_err++; $display("FAIL stall_accepts: got %0d want 4", idx); end
    n_cmp++; if (rgb_in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %0b want 0", rgb_in_ready); end
    pixel_out_ready = 1'b1;
    for (int i = idx; i < NP; i++) send_pixel(v2[i]);
    rgb_in_valid = 1'b0;
    wait_idle();
    n_cmp++; if (out_q.size() != NP) begin n_err++; $display("FAIL stall_count: got %0d want %0d", out_q.size(), NP); end
    for (int i = 0; i < NP && i < out_q.size(); i++) begin
      e = {(i == 0), (i % W == W - 1), gray_ref(v2[i])};
      n_cmp++; if (out_q[i] !== e) begin n_err++; $display("FAIL stall_px%0d: got %h want %h", i, out_q[i], e); end
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL stall_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] e;
    out_q.delete();
    done_cnt = 0;
    pixel_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_pixel(vec1[i]);
    rgb_in_valid = 1'b0;
    tick();
    tick();
    n_cmp++; if (pixel_out_valid !== 1'b1) begin n_err++; $display("FAIL mid_buffered: got %0b want 1", pixel_out_valid); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if ({pixel_out_valid, sof_out, eol_out, frame_done, busy, rgb_in_ready} !== 6'b0) begin
      n_err++; $display("FAIL mid_rst_flags: got %b want 000000", {pixel_out_valid, sof_out, eol_out, frame_done, busy, rgb_in_ready});
    end
    n_cmp++; if (pixel_out !== 8'd0) begin n_err++; $display("FAIL mid_rst_pixel: got %0d want 0", pixel_out); end
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    out_q.delete();
    pixel_out_ready = 1'b1;
    for (int i = 0; i < NP; i++) send_pixel(vec1[i]);
    rgb_in_valid = 1'b0;
    wait_idle();
    n_cmp++; if (out_q.size() != NP) begin n_err++; $display("FAIL mid_count: got %0d want %0d", out_q.size(), NP); end
    for (int i = 0; i < NP && i < out_q.size(); i++) begin
      e = {(i == 0), (i % W == W - 1), g1[i]};
      n_cmp++; if (out_q[i] !== e) begin n_err++; $display("FAIL mid_px%0d: got %h want %h", i, out_q[i], e); end
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL mid_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_random();
    localparam int NF = 6;
    logic [23:0] in_q[$];
    logic [9:0]  e;
    for (int i = 0; i < NF * NP; i++) in_q.push_back(24'($urandom()));
    out_q.delete();
    done_cnt = 0;
    in_done = 1'b0;
    fork
      begin
        for (int i = 0; i < NF * NP; i++) begin
          rgb_in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
          send_pixel(in_q[i]);
        end
        rgb_in_valid = 1'b0;
        in_done = 1'b1;
      end
      begin
        while (!in_done) begin
          pixel_out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        pixel_out_ready = 1'b1;
      end
    join
    wait_idle();
    n_cmp++; if (out_q.size() != NF * NP) begin n_err++; $display("FAIL rnd_count: got %0d want %0d", out_q.size(), NF * NP); end
    for (int i = 0; i < NF * NP && i < out_q.size(); i++) begin
      e = {(i % NP == 0), (i % W == W - 1), gray_ref(in_q[i])};
      n_cmp++; if (out_q[i] !== e) begin n_err++; $display("FAIL rnd_px%0d: got %h want %h", i, out_q[i], e); end
    end
    n_cmp++; if (done_cnt != NF) begin n_err++; $display("FAIL rnd_done_cnt: got %0d want %0d", done_cnt, NF); end
  endtask

  initial begin
    test_reset();
    test_red_latency();
    test_frame();
    test_stall();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
